// File: rtl/branch_eval.sv
// Branch evaluation unit: snapshots a BR instruction, evaluates the n/z/p condition,
// computes the PC-relative target and keeps saturating branch statistics.
module branch_eval #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_Start,
  input  logic [15:0]      i_IR,
  input  logic [15:0]      i_PC,
  input  logic [2:0]       i_NZP,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_BEN,
  output logic             o_LD_PC,
  output logic [15:0]      o_Target,
  output logic             o_CC_Err,
  output logic [CNT_W-1:0] o_Br_Cnt,
  output logic [CNT_W-1:0] o_Taken_Cnt
);

  typedef enum logic [1:0] {StIdle, StEval, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [15:0]      pc_q, pc_d;
  logic [2:0]       nzp_q, nzp_d;
  logic             ben_q, ben_d;
  logic [15:0]      target_q, target_d;
  logic             cc_err_q, cc_err_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic             is_br;
  logic             nzp_onehot;
  logic [15:0]      offset_sext;

  assign is_br       = (ir_q[15:12] == 4'b0000);
  assign nzp_onehot  = (nzp_q == 3'b100) || (nzp_q == 3'b010) || (nzp_q == 3'b001);
  assign offset_sext = {{7{ir_q[8]}}, ir_q[8:0]};

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    pc_d        = pc_q;
    nzp_d       = nzp_q;
    ben_d       = ben_q;
    target_d    = target_q;
    cc_err_d    = cc_err_q;
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (i_Start) begin
          state_d = StEval;
          ir_d    = i_IR;
          pc_d    = i_PC;
          nzp_d   = i_NZP;
        end
      end
      StEval: begin
        // Raw AND even for malformed condition codes; the error flag only reports it.
        ben_d = is_br & |(ir_q[11:9] & nzp_q);
        if (!nzp_onehot) begin
          cc_err_d = 1'b1;
        end
        state_d = StCalc;
      end
      StCalc: begin
        target_d = pc_q + offset_sext;
        // Statistics land on the edge into DONE so they are visible alongside o_Done.
        if (is_br) begin
          if (br_cnt_q != {CNT_W{1'b1}}) begin
            br_cnt_d = br_cnt_q + 1'b1;
          end
          if (ben_q && (taken_cnt_q != {CNT_W{1'b1}})) begin
            taken_cnt_d = taken_cnt_q + 1'b1;
          end
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= StIdle;
      ir_q        <= '0;
      pc_q        <= '0;
      nzp_q       <= '0;
      ben_q       <= 1'b0;
      target_q    <= '0;
      cc_err_q    <= 1'b0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      nzp_q       <= nzp_d;
      ben_q       <= ben_d;
      target_q    <= target_d;
      cc_err_q    <= cc_err_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign o_Busy      = (state_q != StIdle);
  assign o_Done      = (state_q == StDone);
  assign o_LD_PC     = (state_q == StDone) & ben_q;
  assign o_BEN       = ben_q;
  assign o_Target    = target_q;
  assign o_CC_Err    = cc_err_q;
  assign o_Br_Cnt    = br_cnt_q;
  assign o_Taken_Cnt = taken_cnt_q;

endmodule
